// File: rtl/dmem_responder.sv
`timescale 1ns/1ps
// dmem_responder: in-order load/store responder for the core's data port.
// Requests queue in a FIFO; one at a time is aged LATENCY cycles and serviced.
module dmem_responder #(
    parameter int ADDR_MEM_WIDTH = 32,
    parameter int WIDTH_TAG      = 3,
    parameter int DEPTH_LOG2     = 10,
    parameter int QDEPTH         = 4,
    parameter int LATENCY        = 2
) (
    input  logic                      i_clk,
    input  logic                      i_rst,
    input  logic                      i_req_valid,
    output logic                      o_req_ready,
    input  logic [ADDR_MEM_WIDTH-1:0] i_addr,
    input  logic                      i_we,
    input  logic [3:0]                i_wmask,
    input  logic [31:0]               i_wdata,
    input  logic [WIDTH_TAG-1:0]      i_tag,
    input  logic                      i_flush,
    output logic                      o_resp_valid,
    input  logic                      i_resp_ready,
    output logic                      o_resp_we,
    output logic [31:0]               o_resp_data,
    output logic [WIDTH_TAG-1:0]      o_resp_tag
);
    localparam int QW = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;
    localparam int CW = (LATENCY > 1) ? $clog2(LATENCY) : 1;
    localparam logic [QW:0]   QFULL = (QW+1)'(QDEPTH);
    localparam logic [CW-1:0] CNT_INIT = CW'(LATENCY - 1);

    typedef enum logic [1:0] {S_IDLE, S_BUSY, S_RESP} state_t;

    // FIFO storage
    logic [DEPTH_LOG2-1:0] r_q_idx  [QDEPTH];
    logic                  r_q_we   [QDEPTH];
    logic [3:0]            r_q_mask [QDEPTH];
    logic [31:0]           r_q_data [QDEPTH];
    logic [WIDTH_TAG-1:0]  r_q_tag  [QDEPTH];
    logic                  r_q_live [QDEPTH];
    logic [QW-1:0]         r_wptr;
    logic [QW-1:0]         r_rptr;
    logic [QW:0]           r_count;

    // Request currently being aged / serviced
    state_t                r_state;
    logic [CW-1:0]         r_cnt;
    logic [DEPTH_LOG2-1:0] r_cur_idx;
    logic                  r_cur_we;
    logic [3:0]            r_cur_mask;
    logic [31:0]           r_cur_data;
    logic [WIDTH_TAG-1:0]  r_cur_tag;

    logic                  r_resp_valid;
    logic                  r_resp_we;
    logic [31:0]           r_resp_data;
    logic [WIDTH_TAG-1:0]  r_resp_tag;

    logic [31:0] r_mem [2**DEPTH_LOG2];

    logic w_push;
    logic w_pop;
    logic w_head_live;
    logic w_do_write;
    logic w_unused;

    assign o_req_ready = !i_rst && (r_count < QFULL);
    assign w_push      = i_req_valid && o_req_ready;
    assign w_pop       = (r_state == S_IDLE) && (r_count != '0);
    // A load popped on a flush edge is squashed along with the rest.
    assign w_head_live = r_q_live[r_rptr] && !(i_flush && !r_q_we[r_rptr]);
    assign w_do_write  = (r_state == S_BUSY) && (r_cnt == '0) && r_cur_we;
    assign w_unused    = &{1'b0, i_addr[1:0],
                           i_addr[ADDR_MEM_WIDTH-1:DEPTH_LOG2+2]};

    assign o_resp_valid = r_resp_valid;
    assign o_resp_we    = r_resp_we;
    assign o_resp_data  = r_resp_data;
    assign o_resp_tag   = r_resp_tag;

    // FIFO payload: kill queued loads on flush, then write the new entry
    always_ff @(posedge i_clk) begin
        for (int i = 0; i < QDEPTH; i++) begin
            if (i_flush && !r_q_we[i]) r_q_live[i] <= 1'b0;
        end
        if (w_push) begin
            r_q_idx[r_wptr]  <= i_addr[DEPTH_LOG2+1:2];
            r_q_we[r_wptr]   <= i_we;
            r_q_mask[r_wptr] <= i_wmask;
            r_q_data[r_wptr] <= i_wdata;
            r_q_tag[r_wptr]  <= i_tag;
            r_q_live[r_wptr] <= 1'b1;
        end
    end

    // FIFO pointers and occupancy
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) r_wptr <= r_wptr + 1'b1;
            if (w_pop)  r_rptr <= r_rptr + 1'b1;
            r_count <= r_count + {{QW{1'b0}}, w_push} - {{QW{1'b0}}, w_pop};
        end
    end

    // RAM byte-masked store port
    always_ff @(posedge i_clk) begin
        if (w_do_write) begin
            for (int k = 0; k < 4; k++) begin
                if (r_cur_mask[k])
                    r_mem[r_cur_idx][8*k +: 8] <= r_cur_data[8*k +: 8];
            end
        end
    end

    // Service FSM: pop, age, access, hold response until taken
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state      <= S_IDLE;
            r_cnt        <= '0;
            r_cur_idx    <= '0;
            r_cur_we     <= 1'b0;
            r_cur_mask   <= '0;
            r_cur_data   <= '0;
            r_cur_tag    <= '0;
            r_resp_valid <= 1'b0;
            r_resp_we    <= 1'b0;
            r_resp_data  <= '0;
            r_resp_tag   <= '0;
        end else begin
            unique case (r_state)
                S_IDLE: begin
                    if (w_pop) begin
                        r_cur_idx  <= r_q_idx[r_rptr];
                        r_cur_we   <= r_q_we[r_rptr];
                        r_cur_mask <= r_q_mask[r_rptr];
                        r_cur_data <= r_q_data[r_rptr];
                        r_cur_tag  <= r_q_tag[r_rptr];
                        if (w_head_live) begin
                            r_state <= S_BUSY;
                            r_cnt   <= CNT_INIT;
                        end
                    end
                end
                S_BUSY: begin
                    if (i_flush && !r_cur_we) begin
                        r_state <= S_IDLE;
                    end else if (r_cnt != '0) begin
                        r_cnt <= r_cnt - 1'b1;
                    end else begin
                        r_state      <= S_RESP;
                        r_resp_valid <= 1'b1;
                        r_resp_we    <= r_cur_we;
                        r_resp_data  <= r_cur_we ? 32'h0 : r_mem[r_cur_idx];
                        r_resp_tag   <= r_cur_tag;
                    end
                end
                S_RESP: begin
                    if ((i_flush && !r_resp_we) || i_resp_ready) begin
                        r_state      <= S_IDLE;
                        r_resp_valid <= 1'b0;
                    end
                end
                default: begin
                    r_state      <= S_IDLE;
                    r_resp_valid <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_dmem_responder.sv
`timescale 1ns/1ps
// tb_dmem_responder: directed scenarios plus randomized traffic checked
// against a transaction-level queue/memory model.
module tb_dmem_responder;
    logic        clk = 1'b0;
    logic        i_rst, i_req_valid, o_req_ready, i_we, i_flush;
    logic [31:0] i_addr, i_wdata, o_resp_data;
    logic [3:0]  i_wmask;
    logic [2:0]  i_tag, o_resp_tag;
    logic        o_resp_valid, i_resp_ready, o_resp_we;

    always #5 clk = ~clk;

    dmem_responder #(
        .ADDR_MEM_WIDTH(32), .WIDTH_TAG(3), .DEPTH_LOG2(10),
        .QDEPTH(4), .LATENCY(2)
    ) dut (
        .i_clk(clk), .i_rst(i_rst),
        .i_req_valid(i_req_valid), .o_req_ready(o_req_ready),
        .i_addr(i_addr), .i_we(i_we), .i_wmask(i_wmask),
        .i_wdata(i_wdata), .i_tag(i_tag), .i_flush(i_flush),
        .o_resp_valid(o_resp_valid), .i_resp_ready(i_resp_ready),
        .o_resp_we(o_resp_we), .o_resp_data(o_resp_data),
        .o_resp_tag(o_resp_tag)
    );

    typedef struct {
        bit          we;
        logic [3:0]  m;
        logic [31:0] d;
        int          idx;
        logic [2:0]  tag;
    } req_t;

    int          n_cmp = 0;
    int          n_bad = 0;
    int          n_hs  = 0;
    req_t        q[$];
    logic [31:0] mm [1024];
    bit          kn [1024];
    logic [31:0] last_ld;
    bit          acc;

    task automatic chk(input string t, input logic [31:0] got,
                       input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", t, got, exp);
        end
    endtask

    // One clock: drive at negedge, update the model at posedge.
    task automatic cyc(input bit v, input bit we, input logic [3:0] m,
                       input logic [31:0] a, input logic [31:0] d,
                       input logic [2:0] tg, input bit fl, input bit rr);
        logic        s_rdy, s_rv, s_we;
        logic [31:0] s_d;
        logic [2:0]  s_t;
        req_t        e;
        req_t        keep[$];
        s_rdy = o_req_ready;
        s_rv  = o_resp_valid;
        s_we  = o_resp_we;
        s_d   = o_resp_data;
        s_t   = o_resp_tag;
        if (fl && s_rv && rr && !s_we) fl = 1'b0;
        i_req_valid  = v;
        i_we         = we;
        i_wmask      = m;
        i_addr       = a;
        i_wdata      = d;
        i_tag        = tg;
        i_flush      = fl;
        i_resp_ready = rr;
        @(posedge clk);
        acc = v && s_rdy;
        if (s_rv && rr) begin
            n_hs++;
            if (q.size() == 0) begin
                chk("spurious_resp", 32'(s_rv), 32'h0);
            end else begin
                e = q.pop_front();
                chk("resp_tag", 32'(s_t), 32'(e.tag));
                chk("resp_we", 32'(s_we), 32'(e.we));
                if (e.we) begin
                    chk("ack_data", s_d, 32'h0);
                    for (int k = 0; k < 4; k++)
                        if (e.m[k]) mm[e.idx][8*k +: 8] = e.d[8*k +: 8];
                    if (e.m == 4'hF) kn[e.idx] = 1'b1;
                end else begin
                    if (kn[e.idx]) chk("load_data", s_d, mm[e.idx]);
                    last_ld = s_d;
                end
            end
        end
        if (fl) begin
            foreach (q[i]) if (q[i].we) keep.push_back(q[i]);
            q = keep;
        end
        if (acc) q.push_back('{we: we, m: m, d: d,
                               idx: int'((a >> 2) % 1024), tag: tg});
        @(negedge clk);
        if (s_rv && !rr && !(fl && !s_we)) begin
            chk("hold_valid", 32'(o_resp_valid), 32'h1);
            chk("hold_tag", 32'(o_resp_tag), 32'(s_t));
            chk("hold_data", o_resp_data, s_d);
        end
        i_req_valid = 1'b0;
        i_flush     = 1'b0;
    endtask

    task automatic idle(input bit rr);
        cyc(1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 3'h0, 1'b0, rr);
    endtask

    task automatic wait_resp(output int n);
        n = 0;
        while (o_resp_valid !== 1'b1 && n < 50) begin
            idle(1'b0);
            n++;
        end
    endtask

    task automatic send(input bit we, input logic [3:0] m,
                        input logic [31:0] a, input logic [31:0] d,
                        input logic [2:0] tg, input bit rr);
        int k = 0;
        acc = 1'b0;
        while (!acc && k < 50) begin
            cyc(1'b1, we, m, a, d, tg, 1'b0, rr);
            k++;
        end
        chk("send_accepted", 32'(acc), 32'h1);
    endtask

    task automatic drain();
        int k = 0;
        while (q.size() > 0 && k < 300) begin
            idle(1'b1);
            k++;
        end
        chk("drain_empty", q.size(), 0);
    endtask

    initial begin
        int n, nacc, hs0;
        i_rst = 1'b1; i_req_valid = 1'b0; i_we = 1'b0; i_wmask = '0;
        i_addr = '0; i_wdata = '0; i_tag = '0; i_flush = 1'b0;
        i_resp_ready = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_req_ready", 32'(o_req_ready), 32'h0);
        chk("rst_resp_valid", 32'(o_resp_valid), 32'h0);
        chk("rst_resp_we", 32'(o_resp_we), 32'h0);
        chk("rst_resp_data", o_resp_data, 32'h0);
        chk("rst_resp_tag", 32'(o_resp_tag), 32'h0);
        i_rst = 1'b0;
        #1 chk("rel_req_ready", 32'(o_req_ready), 32'h1);
        @(negedge clk);

        // store then load, with latency from accept/handshake
        send(1'b1, 4'hF, 32'h10, 32'hDEADBEEF, 3'd1, 1'b0);
        wait_resp(n);
        chk("store_latency", n, 3);
        chk("store_ack_tag", 32'(o_resp_tag), 32'd1);
        cyc(1'b1, 1'b0, 4'h0, 32'h10, 32'h0, 3'd2, 1'b0, 1'b1);
        wait_resp(n);
        chk("load_latency", n, 3);
        idle(1'b1);
        chk("load_deadbeef", last_ld, 32'hDEADBEEF);

        // byte masks, misaligned and aliased loads
        send(1'b1, 4'hF, 32'h20, 32'h11223344, 3'd3, 1'b1);
        send(1'b1, 4'b0101, 32'h20, 32'hAABBCCDD, 3'd4, 1'b1);
        send(1'b0, 4'h0, 32'h20, 32'h0, 3'd5, 1'b1);
        drain();
        chk("mask_merge", last_ld, 32'h11BB33DD);
        send(1'b0, 4'h0, 32'h23, 32'h0, 3'd6, 1'b1);
        drain();
        chk("misaligned", last_ld, 32'h11BB33DD);
        send(1'b0, 4'h0, 32'h0000_1020, 32'h0, 3'd7, 1'b1);
        drain();
        chk("aliased", last_ld, 32'h11BB33DD);
        send(1'b1, 4'h0, 32'h20, 32'hFFFFFFFF, 3'd0, 1'b1);
        send(1'b0, 4'h0, 32'h20, 32'h0, 3'd1, 1'b1);
        drain();
        chk("mask_zero", last_ld, 32'h11BB33DD);

        // fill with consumer stalled, hold response, then drain in order
        nacc = 0;
        for (int i = 0; i < 14; i++) begin
            cyc(nacc < 6, 1'b0, 4'h0, 32'h20, 32'h0, 3'(nacc),
                1'b0, 1'b0);
            if (acc) nacc++;
        end
        chk("fill_accepts", nacc, 5);
        chk("full_not_ready", 32'(o_req_ready), 32'h0);
        chk("stalled_valid", 32'(o_resp_valid), 32'h1);
        idle(1'b1);
        chk("bubble", 32'(o_resp_valid), 32'h0);
        drain();

        // flush while load t1 is aging
        hs0 = n_hs;
        cyc(1'b1, 1'b0, 4'h0, 32'h30, 32'h0, 3'd1, 1'b0, 1'b1);
        cyc(1'b1, 1'b1, 4'hF, 32'h30, 32'hCAFEF00D, 3'd2, 1'b0, 1'b1);
        cyc(1'b1, 1'b0, 4'h0, 32'h30, 32'h0, 3'd3, 1'b0, 1'b1);
        cyc(1'b1, 1'b0, 4'h0, 32'h30, 32'h0, 3'd4, 1'b1, 1'b1);
        chk("flush_edge_accept", 32'(acc), 32'h1);
        drain();
        repeat (4) idle(1'b1);
        chk("flush_resp_count", n_hs - hs0, 2);
        chk("flush_store_data", last_ld, 32'hCAFEF00D);

        // async reset while a response is pending
        send(1'b0, 4'h0, 32'h10, 32'h0, 3'd5, 1'b0);
        send(1'b0, 4'h0, 32'h10, 32'h0, 3'd6, 1'b0);
        send(1'b0, 4'h0, 32'h10, 32'h0, 3'd7, 1'b0);
        wait_resp(n);
        chk("pre_rst_valid", 32'(o_resp_valid), 32'h1);
        #2 i_rst = 1'b1;
        #1 chk("arst_valid", 32'(o_resp_valid), 32'h0);
        chk("arst_ready", 32'(o_req_ready), 32'h0);
        chk("arst_tag", 32'(o_resp_tag), 32'h0);
        q.delete();
        @(negedge clk);
        i_rst = 1'b0;
        #1 chk("arst_rel_ready", 32'(o_req_ready), 32'h1);
        repeat (6) idle(1'b1);
        chk("arst_no_resp", 32'(o_resp_valid), 32'h0);

        // randomized traffic over 16 pre-written words
        for (int w = 0; w < 16; w++)
            send(1'b1, 4'hF, 32'(32'h100 + 4 * w), $urandom, 3'(w), 1'b1);
        drain();
        for (int i = 0; i < 600; i++) begin
            logic [31:0] a;
            a = ($urandom & 32'hFFFF_F000) |
                ((32'h40 + $urandom_range(0, 15)) << 2) | ($urandom & 3);
            cyc($urandom_range(0, 9) < 6, 1'($urandom), 4'($urandom), a,
                $urandom, 3'($urandom), $urandom_range(0, 19) == 0,
                $urandom_range(0, 9) < 7);
        end
        drain();
        repeat (4) idle(1'b1);
        chk("final_idle", 32'(o_resp_valid), 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end
endmodule
